// File: rtl/apb_link_responder.sv
// APB-over-serdes far-end responder: runs each decoded request frame as one APB
// transaction and returns a response frame on the TX word stream.
module apb_link_responder #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic                  rx_start,
    input  logic [31:0]           rx_data,
    output logic                  tx_valid,
    output logic                  tx_start,
    output logic [31:0]           tx_data,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [15:0]           drop_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        RSP_HDR,
        RSP_DATA
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata;
    logic             busy;
    logic             accept_hdr;
    logic             drop;

    // A header is taken in IDLE, and in WDATA it replaces the unfinished write.
    always_comb begin
        busy       = (state == SETUP) || (state == ACCESS) ||
                     (state == RSP_HDR) || (state == RSP_DATA);
        accept_hdr = rx_valid && rx_start && ((state == IDLE) || (state == WDATA));
        drop       = rx_valid && (((state == IDLE) && !rx_start) ||
                                  ((state == WDATA) && rx_start) ||
                                  (busy && rx_start));
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata    <= '0;
            paddr    <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            pstrb    <= '0;
            tx_valid <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else if (accept_hdr) begin
            paddr  <= rx_data[ADDR_WIDTH-1:0];
            pwrite <= rx_data[31];
            pstrb  <= rx_data[31] ? rx_data[27:24] : 4'h0;
            if (rx_data[31]) begin
                state <= WDATA;
            end else begin
                state <= SETUP;
                psel  <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: ;
                WDATA: begin
                    if (rx_valid) begin
                        pwdata <= rx_data;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= CNT_W'(1);
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        if (!pwrite) rdata <= prdata;
                        tx_valid <= 1'b1;
                        tx_start <= 1'b1;
                        tx_data  <= {pslverr, pwrite, 1'b0, 29'h0};
                        state    <= RSP_HDR;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        rdata    <= '0;
                        tx_valid <= 1'b1;
                        tx_start <= 1'b1;
                        tx_data  <= {1'b1, pwrite, 1'b1, 29'h0};
                        state    <= RSP_HDR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RSP_HDR: begin
                    if (tx_ready) begin
                        tx_start <= 1'b0;
                        if (pwrite) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= rdata;
                            state   <= RSP_DATA;
                        end
                    end
                end
                RSP_DATA: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_apb_link_responder.sv
// Scoreboard bench for apb_link_responder: expected response words are queued as
// requests are driven and popped as the TX handshake completes.
module tb_apb_link_responder;

    logic        pclk = 1'b0;
    logic        rst;
    logic        rx_valid, rx_start;
    logic [31:0] rx_data;
    logic        tx_valid, tx_start;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic [9:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int exp_drops = 0;
    logic [32:0] exp_q[$];

    apb_link_responder #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(8)) dut (
        .pclk(pclk), .rst(rst),
        .rx_valid(rx_valid), .rx_start(rx_start), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .drop_count(drop_count)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 0; rx_start = 0; rx_data = 0;
        tx_ready = 1; prdata = 0; pready = 0; pslverr = 0;
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, tx_valid, tx_start, tx_data, paddr, pwdata, pstrb, drop_count} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: psel=%b penable=%b tx_valid=%b tx_data=%h drop=%0d, required all zero",
                     psel, penable, tx_valid, tx_data, drop_count);
        end
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_read();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h000002A4;
        exp_q.push_back({1'b1, 32'h00000000});
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        checks++;
        if ({psel, penable, pwrite, pstrb, paddr} !== {1'b1, 1'b0, 1'b0, 4'h0, 10'h2A4}) begin
            failures++;
            $display("[TB] FAIL read_setup: got psel=%b penable=%b pwrite=%b pstrb=%h paddr=%h, required 1 0 0 0 2a4",
                     psel, penable, pwrite, pstrb, paddr);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL read_access1: got psel/penable=%b%b, required 11", psel, penable);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, paddr} !== {2'b11, 10'h2A4}) begin
            failures++;
            $display("[TB] FAIL read_access2: got psel/penable=%b%b paddr=%h, required 11 2a4", psel, penable, paddr);
        end
        pready = 1; prdata = 32'hDEADBEEF;
        @(negedge pclk);
        pready = 0; prdata = 0;
        checks++;
        if (psel !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_release: got psel=%b, required 0", psel);
        end
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL read_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL read_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_write();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h8F000010;
        @(negedge pclk);
        rx_start = 0; rx_data = 32'h12345678;
        exp_q.push_back({1'b1, 32'h40000000});
        @(negedge pclk);
        rx_valid = 0;
        checks++;
        if ({psel, penable, pwrite, pstrb, pwdata, paddr} !== {3'b101, 4'hF, 32'h12345678, 10'h010}) begin
            failures++;
            $display("[TB] FAIL write_setup: got psel=%b penable=%b pwrite=%b pstrb=%h pwdata=%h paddr=%h, required 1 0 1 f 12345678 010",
                     psel, penable, pwrite, pstrb, pwdata, paddr);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, pstrb, pwdata} !== {3'b111, 4'hF, 32'h12345678}) begin
            failures++;
            $display("[TB] FAIL write_access: got psel/penable/pwrite=%b%b%b pstrb=%h pwdata=%h, required 111 f 12345678",
                     psel, penable, pwrite, pstrb, pwdata);
        end
        pready = 1;
        @(negedge pclk);
        pready = 0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL write_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL write_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_header_only: got tx_valid=%b after header, required 0", tx_valid);
        end
    endtask

    task automatic test_timeout();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h00000055;
        exp_q.push_back({1'b1, 32'hA0000000});
        exp_q.push_back({1'b0, 32'h00000000});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        checks++;
        if ({psel, penable} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL timeout_setup: got psel/penable=%b%b, required 10", psel, penable);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            checks++;
            if ({psel, penable} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL timeout_access: cycle %0d got psel/penable=%b%b, required 11", i + 1, psel, penable);
            end
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL timeout_release: got psel/penable=%b%b, required 00", psel, penable);
        end
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL timeout_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL timeout_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_aborted_write();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h8F000020;
        @(negedge pclk);
        rx_data = 32'h00000033;
        exp_drops++;
        exp_q.push_back({1'b1, 32'h00000000});
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        checks++;
        if (drop_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL abort_drop_count: got %0d, required 1", drop_count);
        end
        checks++;
        if ({psel, pwrite, pstrb, paddr} !== {1'b1, 1'b0, 4'h0, 10'h033}) begin
            failures++;
            $display("[TB] FAIL abort_setup: got psel=%b pwrite=%b pstrb=%h paddr=%h, required 1 0 0 033",
                     psel, pwrite, pstrb, paddr);
        end
        @(negedge pclk);
        pready = 1; prdata = 32'hCAFEF00D;
        @(negedge pclk);
        pready = 0; prdata = 0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL abort_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL abort_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h00000077;
        exp_q.push_back({1'b1, 32'h00000000});
        exp_q.push_back({1'b0, 32'h11112222});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0; tx_ready = 0;
        @(negedge pclk);
        pready = 1; prdata = 32'h11112222;
        @(negedge pclk);
        pready = 0; prdata = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge pclk);
            checks++;
            if ({tx_valid, tx_start, tx_data} !== {2'b11, 32'h00000000}) begin
                failures++;
                $display("[TB] FAIL bp_hold: cycle %0d got valid=%b start=%b data=%h, required 1 1 00000000",
                         i, tx_valid, tx_start, tx_data);
            end
            if (i == 2) begin
                rx_valid = 1; rx_start = 1; rx_data = 32'h00000001;
                exp_drops++;
            end
            if (i == 3) begin
                rx_valid = 0; rx_start = 0;
            end
        end
        @(negedge pclk);
        tx_ready = 1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL bp_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL bp_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge pclk);
        checks++;
        if ({psel, drop_count} !== {1'b0, 16'(exp_drops)}) begin
            failures++;
            $display("[TB] FAIL bp_drop: got psel=%b drop=%0d, required 0 %0d", psel, drop_count, exp_drops);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h00000010;
        exp_q.push_back({1'b1, 32'h00000000});
        exp_q.push_back({1'b0, 32'h0BADF00D});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        @(negedge pclk);
        pready = 1; prdata = 32'h0BADF00D;
        @(negedge pclk);
        pready = 0; prdata = 0;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL b2b_rsp: got %h, required %h", got, want);
                end
            end else begin
                failures++;
                $display("[TB] FAIL b2b_rsp_valid: word %0d got tx_valid=%b, required 1", w, tx_valid);
            end
            if (w == 1) begin
                rx_valid = 1; rx_start = 1; rx_data = 32'h00000020;
                exp_drops++;
            end
            @(negedge pclk);
        end
        exp_q.delete();
        checks++;
        if ({tx_valid, psel, drop_count} !== {2'b00, 16'(exp_drops)}) begin
            failures++;
            $display("[TB] FAIL b2b_drop: got tx_valid=%b psel=%b drop=%0d, required 0 0 %0d",
                     tx_valid, psel, drop_count, exp_drops);
        end
        exp_q.push_back({1'b1, 32'h00000000});
        exp_q.push_back({1'b0, 32'h00000005});
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        checks++;
        if ({psel, penable, paddr, drop_count} !== {2'b10, 10'h020, 16'(exp_drops)}) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got psel/penable=%b%b paddr=%h drop=%0d, required 10 020 %0d",
                     psel, penable, paddr, drop_count, exp_drops);
        end
        @(negedge pclk);
        pready = 1; prdata = 32'h00000005;
        @(negedge pclk);
        pready = 0; prdata = 0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL b2b_rsp2: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stray_word();
        rx_valid = 1; rx_start = 0; rx_data = 32'hFFFFFFFF;
        exp_drops++;
        @(negedge pclk);
        rx_valid = 0;
        checks++;
        if ({psel, drop_count} !== {1'b0, 16'(exp_drops)}) begin
            failures++;
            $display("[TB] FAIL stray_drop: got psel=%b drop=%0d, required 0 %0d", psel, drop_count, exp_drops);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [32:0] got, want;
        rx_valid = 1; rx_start = 1; rx_data = 32'h00000099;
        @(negedge pclk);
        rx_valid = 0; rx_start = 0;
        @(negedge pclk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rstmid_access: got psel/penable=%b%b, required 11", psel, penable);
        end
        #2 rst = 1'b1;
        exp_drops = 0;
        #1;
        checks++;
        if ({psel, penable, tx_valid, drop_count} !== {3'b000, 16'd0}) begin
            failures++;
            $display("[TB] FAIL rstmid_async: got psel=%b penable=%b tx_valid=%b drop=%0d, required 0 0 0 0",
                     psel, penable, tx_valid, drop_count);
        end
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_no_rsp: got tx_valid=%b, required 0", tx_valid);
        end
        rx_valid = 1; rx_start = 1; rx_data = 32'h83000005;
        @(negedge pclk);
        rx_start = 0; rx_data = 32'hA5A5A5A5;
        exp_q.push_back({1'b1, 32'hC0000000});
        @(negedge pclk);
        rx_valid = 0;
        checks++;
        if ({psel, pwrite, pstrb, pwdata, paddr} !== {2'b11, 4'h3, 32'hA5A5A5A5, 10'h005}) begin
            failures++;
            $display("[TB] FAIL rstmid_setup: got psel=%b pwrite=%b pstrb=%h pwdata=%h paddr=%h, required 1 1 3 a5a5a5a5 005",
                     psel, pwrite, pstrb, pwdata, paddr);
        end
        @(negedge pclk);
        pready = 1; pslverr = 1;
        @(negedge pclk);
        pready = 0; pslverr = 0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (tx_valid && tx_ready) begin
                got = {tx_start, tx_data}; want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL rstmid_rsp: got %h, required %h", got, want);
                end
            end
            @(negedge pclk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL rstmid_rsp_count: %0d words missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_aborted_write();
        test_backpressure();
        test_back_to_back();
        test_stray_word();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
